cntimple: RTL and testbench
===========================

Name: cntimple

Overview:
- Modulo-20 up/down event counter for board bring-up.
- Each press of push-switch SW1 moves the count one step. Switch SW selects the direction.
- The count is shown in decimal on two active-low 7-segment displays, HEX1 (tens) and HEX0 (units).
- HEX2..HEX7 are always blank. The block sits directly at the top level between the board switches and the displays.

Parameters:
- MODULUS, 20: number of count states, 0..MODULUS-1. Legal range 2..100.
- CNT_W, 5: counter register width. Must satisfy 2**CNT_W >= MODULUS.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- SW0  in  1  asynchronous active-low reset (0 = reset).
- SW1  in  1  step request; one step per 0->1 transition.
- SW  in  1  direction: 0 = count up, 1 = count down.
- HEX0  out  7  units digit, segments {g,f,e,d,c,b,a}, bit0 = a, active-low.
- HEX1  out  7  tens digit, same encoding.
- HEX2..HEX7  out  7 each  constant 7'h7F (all segments off).

Behaviour:
- State: count[CNT_W-1:0] and sw1_q, the previous sample of SW1.
- Reset (SW0 = 0, asynchronous, no clock needed):
  - count = 0 and sw1_q = 0.
  - HEX0 = 7'h40 ('0'), HEX1 = 7'h40 ('0'), HEX2..HEX7 = 7'h7F.
- Reset release is not synchronised inside the block. Counting resumes at the first clock edge after SW0 = 1.
- Step detection:
  - step = SW1 & ~sw1_q, combinational.
  - sw1_q <= SW1 on every clock edge.
  - Exactly one step per SW1 rising transition, however long SW1 is held high.
  - A 1->0 transition of SW1 does nothing.
- Count update on each clock edge with step = 1:
  - Up (SW = 0): count = (count == MODULUS-1) ? 0 : count + 1.
  - Down (SW = 1): count = (count == 0) ? MODULUS-1 : count - 1.
- Wrap-around: 19 -> 0 going up, 0 -> 19 going down.
- If step = 0, count holds.
- Direction is sampled on the same edge as step. A change of SW simultaneous with the step edge takes effect for that step.
- Latency: count changes on the first rising clock edge at which SW1 is sampled 1 after having been sampled 0.
- Displays are combinational from the registered count, so they update in the same cycle:
  - tens = count / 10, units = count % 10.
  - Leading zero is shown (count 5 displays "05").
- Active-low digit encodings: 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
- Out-of-range count values (unreachable) force both digits blank (7'h7F) and the count self-corrects to 0 on the next step.
- Reset asserted mid-operation clears everything immediately, including a pending step.

Optional Feature:
- Macro: CNTIMPLE_SYNC_EN.
- When defined:
  - SW1 and SW each pass through a two-flop synchronizer before edge detection and direction use.
  - Step latency grows by 2 clock cycles.
  - Synchronizer flops reset to 0.
- When undefined: the raw inputs are used as described above.

Decomposition:
- Package cntimple_pkg holds:
  - the ten digit segment constants;
  - SEG_BLANK = 7'h7F;
  - the default MODULUS and CNT_W.
- One sub-module, seg7_dec: 4-bit BCD in, 7-bit active-low segments out, blank for inputs above 9. It is instantiated twice, for units and tens.

Test Plan:
- Reset: SW0 = 0 -> count 0, HEX0 = HEX1 = 7'h40, HEX2..HEX7 = 7'h7F, independent of clock.
- Count up: SW = 0, 19 SW1 pulses (high 20 ns, low 20 ns, 20 ns clock period) -> counts 1..19; after the 19th pulse HEX1 = 7'h79, HEX0 = 7'h10. A 20th pulse -> 0 ("00").
- Count down with wrap: SW = 1 from count 0 -> 19, 18 ... 0, one step per pulse; at count 10 HEX1 = 7'h79, HEX0 = 7'h40.
- Held switch: SW1 held high for 10 clock cycles -> exactly one step.
- Direction change: at count 7, set SW = 1 on the same edge as a step -> count 6.
- Asynchronous reset: SW0 pulsed low mid-cycle at count 13 -> immediate 0, with no clock edge needed.

Source files
------------

// File: rtl/cntimple_pkg.sv
// Shared constants for the cntimple up/down counter: default sizing and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}, bit0 = a).
package cntimple_pkg;

  localparam int DEF_MODULUS = 20;
  localparam int DEF_CNT_W   = 5;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/cntimple_seg7_dec.sv
// BCD digit to active-low 7-segment pattern, purely combinational.
// Any input above 9 blanks the digit.
module seg7_dec
  import cntimple_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cntimple.sv
// Modulo-MODULUS up/down event counter stepped by SW1 rising edges, shown as two decimal digits.
// Define CNTIMPLE_SYNC_EN to pass SW1/SW through two-flop synchronizers (+2 cycles step latency).
module cntimple
  import cntimple_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [6:0] HEX6,
  output logic [6:0] HEX7
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic             w_sw1;
  logic             w_dir;
  logic             w_step;
  logic             r_sw1_q;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic             w_in_range;
  logic [31:0]      w_cnt32;
  logic [3:0]       w_tens;
  logic [3:0]       w_units;

`ifdef CNTIMPLE_SYNC_EN
  logic [1:0] r_sw1_sync;
  logic [1:0] r_dir_sync;

  always_ff @(posedge clock or negedge SW0) begin
    if (!SW0) begin
      r_sw1_sync <= 2'b00;
      r_dir_sync <= 2'b00;
    end else begin
      r_sw1_sync <= {r_sw1_sync[0], SW1};
      r_dir_sync <= {r_dir_sync[0], SW};
    end
  end

  assign w_sw1 = r_sw1_sync[1];
  assign w_dir = r_dir_sync[1];
`else
  assign w_sw1 = SW1;
  assign w_dir = SW;
`endif

  assign w_step = w_sw1 & ~r_sw1_q;

  // Unreachable out-of-range counts recover to 0 on the next step.
  always_comb begin
    w_next = r_count;
    if (w_step) begin
      if (r_count > LAST)
        w_next = '0;
      else if (!w_dir)
        w_next = (r_count == LAST) ? '0 : r_count + 1'b1;
      else
        w_next = (r_count == '0) ? LAST : r_count - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge SW0) begin
    if (!SW0) begin
      r_sw1_q <= 1'b0;
      r_count <= '0;
    end else begin
      r_sw1_q <= w_sw1;
      r_count <= w_next;
    end
  end

  // A digit value of 15 drives both decoders to blank for out-of-range counts.
  assign w_in_range = (r_count <= LAST);
  assign w_cnt32    = 32'(r_count);
  assign w_tens     = w_in_range ? 4'(w_cnt32 / 32'd10) : 4'hF;
  assign w_units    = w_in_range ? 4'(w_cnt32 % 32'd10) : 4'hF;

  seg7_dec u_dec_units (
    .i_bcd (w_units),
    .o_seg (HEX0)
  );

  seg7_dec u_dec_tens (
    .i_bcd (w_tens),
    .o_seg (HEX1)
  );

  assign HEX2 = SEG_BLANK;
  assign HEX3 = SEG_BLANK;
  assign HEX4 = SEG_BLANK;
  assign HEX5 = SEG_BLANK;
  assign HEX6 = SEG_BLANK;
  assign HEX7 = SEG_BLANK;

endmodule

// File: tb/tb_cntimple.sv
// Bench for cntimple: stimulus queues expected display pairs, a negedge monitor
// pops and compares whenever the displayed value changes.
module tb_cntimple;

  logic       clock;
  logic       SW0;
  logic       SW1;
  logic       SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic [13:0] prev_disp;
  logic        mon_en = 1'b0;
  logic [6:0]  seg_tab [0:9];
  int          model_cnt;

  cntimple dut (
    .clock (clock),
    .SW0   (SW0),
    .SW1   (SW1),
    .SW    (SW),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5),
    .HEX6  (HEX6),
    .HEX7  (HEX7)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [13:0] disp_of(input int n);
    return {seg_tab[n / 10], seg_tab[n % 10]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every change of the two digits must match the next queued expectation.
  always @(negedge clock) begin
    logic [13:0] cur;
    logic [13:0] want;
    cur = {HEX1, HEX0};
    if (mon_en && cur !== prev_disp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h, expected no change from %h", cur, prev_disp);
      end else begin
        want = exp_q.pop_front();
        if (cur !== want) begin
          errors++;
          $display("FAIL display: got %h, expected %h", cur, want);
        end
      end
      checks++;
      if ({HEX2, HEX3, HEX4, HEX5, HEX6, HEX7} !== {6{7'h7F}}) begin
        errors++;
        $display("FAIL blank_digits: got %h, expected %h",
                 {HEX2, HEX3, HEX4, HEX5, HEX6, HEX7}, {6{7'h7F}});
      end
    end
    prev_disp = cur;
  end

  task automatic step_model(input logic dir);
    if (!dir) model_cnt = (model_cnt == 19) ? 0 : model_cnt + 1;
    else      model_cnt = (model_cnt == 0) ? 19 : model_cnt - 1;
  endtask

  // One SW1 pulse: high one clock period, low one period; expects a single step.
  task automatic pulse(input logic dir, input int hold_cycles);
    step_model(dir);
    exp_q.push_back(disp_of(model_cnt));
    SW  = dir;
    SW1 = 1'b1;
    repeat (hold_cycles) @(negedge clock);
    SW1 = 1'b0;
    @(negedge clock);
    #2;
    check("step_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    model_cnt = 0;

    SW0 = 1'b0;
    SW1 = 1'b0;
    SW  = 1'b0;
    #3;
    // Reset takes effect before any clock edge.
    check("reset_hex0", 32'(HEX0), 32'h40);
    check("reset_hex1", 32'(HEX1), 32'h40);
    check("reset_blank", 32'(HEX7), 32'h7F);
    repeat (2) @(negedge clock);
    SW0 = 1'b1;
    @(negedge clock);
    #1;
    mon_en = 1'b1;

    // Up through 19 and wrap to 00.
    for (int i = 0; i < 19; i++) pulse(1'b0, 1);
    check("up_19", 32'({HEX1, HEX0}), 32'({7'h79, 7'h10}));
    pulse(1'b0, 1);
    check("up_wrap", 32'({HEX1, HEX0}), 32'({7'h40, 7'h40}));

    // Down from 0 wraps to 19, then back to 0.
    for (int i = 0; i < 20; i++) begin
      pulse(1'b1, 1);
      if (model_cnt == 10)
        check("down_10", 32'({HEX1, HEX0}), 32'({7'h79, 7'h40}));
    end

    // Held switch: one step only.
    pulse(1'b0, 10);
    check("held_one_step", 32'({HEX1, HEX0}), 32'({7'h40, 7'h79}));

    // Up to 7, then a down step with direction changed on the step edge.
    for (int i = 0; i < 6; i++) pulse(1'b0, 1);
    pulse(1'b1, 1);
    check("dir_change", 32'({HEX1, HEX0}), 32'({7'h40, 7'h02}));

    // Up to 13, then async reset in mid high phase.
    for (int i = 0; i < 7; i++) pulse(1'b0, 1);
    check("at_13", 32'({HEX1, HEX0}), 32'({7'h79, 7'h30}));
    @(posedge clock);
    #4;
    model_cnt = 0;
    exp_q.push_back(disp_of(0));
    SW0 = 1'b0;
    #2;
    check("async_rst_hex0", 32'(HEX0), 32'h40);
    check("async_rst_hex1", 32'(HEX1), 32'h40);
    @(negedge clock);
    SW0 = 1'b1;
    @(negedge clock);
    #2;
    check("rst_drained", 32'(exp_q.size()), 32'd0);

    // Counting resumes after reset.
    pulse(1'b0, 1);
    pulse(1'b0, 1);
    check("after_rst", 32'({HEX1, HEX0}), 32'({7'h40, 7'h24}));

    repeat (4) @(negedge clock);
    #2;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
